// File: rtl/neuron_sequencer.sv
// neuron_sequencer: drives one image classification through the neuron
// calculator: clear the accumulator, stream NUM_WORDS pixel/weight words,
// let the pipeline drain, request the result, then capture the decision.
// All outputs come straight from flops. The next-cycle value of every
// output is derived from the next state, so each output lines up with the
// state it belongs to.
// Optional feature: define NEURON_SEQ_CYCLE_CNT_EN to build the 16-bit
// start-to-done cycle counter; otherwise o_cycle_count is tied to zero.
module neuron_sequencer #(
  parameter int DATA_WIDTH = 24,
  parameter int Addr_Depth = 12,
  parameter int NUM_WORDS  = 4096
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  output logic [Addr_Depth-1:0] o_mem_addr,
  output logic                  o_mem_rd_en,
  output logic                  o_nc_clear,
  output logic                  o_nc_enable,
  output logic                  o_nc_get_result,
  input  logic                  i_nc_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_result,
  output logic [15:0]           o_cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_DRAIN   = 3'd3,
    S_RESULT  = 3'd4,
    S_CAPTURE = 3'd5
  } state_t;

  // Address of the final word; RUN leaves after presenting it, so the
  // counter never needs to wrap even when NUM_WORDS fills the address space.
  localparam logic [Addr_Depth-1:0] LP_LAST_ADDR = Addr_Depth'(NUM_WORDS - 1);

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_drain_last;   // set during the second DRAIN cycle
  logic [Addr_Depth-1:0]   r_mem_addr;
  logic                    r_mem_rd_en;
  logic                    r_nc_clear;
  logic                    r_nc_enable;
  logic                    r_nc_get_result;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_result;

  logic [Addr_Depth-1:0]   w_mem_addr_next;
  logic                    w_mem_rd_en_next;
  logic                    w_nc_clear_next;
  logic                    w_nc_enable_next;
  logic                    w_nc_get_result_next;
  logic                    w_busy_next;
  logic                    w_done_next;

  // State register plus the DRAIN sub-cycle flag
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_drain_last <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_drain_last <= (r_state == S_DRAIN) && (w_state_next == S_DRAIN);
    end
  end

  // Next-state logic; abort wins over everything, start is only seen in IDLE
  always_comb begin
    w_state_next = r_state;
    if (r_state == S_IDLE) begin
      if (i_start && !i_abort) w_state_next = S_CLEAR;
    end else if (i_abort) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_CLEAR:   w_state_next = S_RUN;
        S_RUN:     if (r_mem_addr == LP_LAST_ADDR) w_state_next = S_DRAIN;
        S_DRAIN:   if (r_drain_last) w_state_next = S_RESULT;
        S_RESULT:  w_state_next = S_CAPTURE;
        S_CAPTURE: w_state_next = S_IDLE;
        default:   w_state_next = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so the output flops match the state
  always_comb begin
    w_mem_addr_next      = '0;
    w_mem_rd_en_next     = 1'b0;
    w_nc_clear_next      = 1'b0;
    w_nc_enable_next     = 1'b0;
    w_nc_get_result_next = 1'b0;
    w_busy_next          = (w_state_next != S_IDLE);
    w_done_next          = 1'b0;
    case (w_state_next)
      S_CLEAR:   w_nc_clear_next = 1'b1;
      S_RUN: begin
        w_mem_rd_en_next = 1'b1;
        w_nc_enable_next = 1'b1;
        w_mem_addr_next  = (r_state == S_RUN) ? r_mem_addr + 1'b1 : '0;
      end
      S_RESULT:  w_nc_get_result_next = 1'b1;
      S_CAPTURE: w_done_next = 1'b1;
      default:   ;
    endcase
  end

  // Output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem_addr      <= '0;
      r_mem_rd_en     <= 1'b0;
      r_nc_clear      <= 1'b0;
      r_nc_enable     <= 1'b0;
      r_nc_get_result <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_mem_addr      <= w_mem_addr_next;
      r_mem_rd_en     <= w_mem_rd_en_next;
      r_nc_clear      <= w_nc_clear_next;
      r_nc_enable     <= w_nc_enable_next;
      r_nc_get_result <= w_nc_get_result_next;
      r_busy          <= w_busy_next;
      r_done          <= w_done_next;
    end
  end

  // Decision register: loads the calculator output at the end of CAPTURE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_result <= 1'b0;
    end else if (r_state == S_CAPTURE && !i_abort) begin
      r_result <= i_nc_out;
    end
  end

`ifdef NEURON_SEQ_CYCLE_CNT_EN
  logic [15:0] r_cycle_cnt;

  // Start-to-done counter: zeroed when a run begins, saturating, frozen in IDLE
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cycle_cnt <= '0;
    end else if (r_state == S_IDLE && w_state_next == S_CLEAR) begin
      r_cycle_cnt <= '0;
    end else if (r_state != S_IDLE && r_cycle_cnt != 16'hFFFF) begin
      r_cycle_cnt <= r_cycle_cnt + 16'd1;
    end
  end

  assign o_cycle_count = r_cycle_cnt;
`else
  assign o_cycle_count = '0;
`endif

  assign o_mem_addr      = r_mem_addr;
  assign o_mem_rd_en     = r_mem_rd_en;
  assign o_nc_clear      = r_nc_clear;
  assign o_nc_enable     = r_nc_enable;
  assign o_nc_get_result = r_nc_get_result;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_result        = r_result;

endmodule

// File: doc/neuron_sequencer.md
NEURON_SEQUENCER -- requirements
Module: neuron_sequencer

Interface
- REQ-001 Parameter DATA_WIDTH, default 24, width of one packed pixel word (3 x 8-bit pixels).
- REQ-002 Parameter Addr_Depth, default 12, width of the shared pixel/weight memory address.
- REQ-003 Parameter NUM_WORDS, default 4096, words per image; legal range 1..2^Addr_Depth.
- REQ-004 clock  input  1  single clock; all logic on rising edge.
- REQ-005 reset  input  1  asynchronous, active-low reset.
- REQ-006 start  input  1  request one image classification; sampled in IDLE only.
- REQ-007 abort  input  1  cancel the current classification.
- REQ-008 mem_addr  output  Addr_Depth  word address to pixel and weight memories.
- REQ-009 mem_rd_en  output  1  memory read strobe; read data valid on the following cycle.
- REQ-010 nc_clear  output  1  synchronous clear to the neuron calculator accumulator.
- REQ-011 nc_enable  output  1  accumulate enable to the neuron calculator.
- REQ-012 nc_get_result  output  1  result-capture strobe to the neuron calculator.
- REQ-013 nc_out  input  1  neuron calculator decision (1 = cat).
- REQ-014 busy  output  1  high in every state except IDLE.
- REQ-015 done  output  1  one-cycle pulse when a classification completes.
- REQ-016 result  output  1  registered decision of the last completed classification.
- REQ-017 cycle_count  output  16  start-to-done cycle count (see Configuration).

Function
- REQ-018 The FSM SHALL have states IDLE, CLEAR, RUN, DRAIN, RESULT, CAPTURE.
- REQ-019 IDLE -> CLEAR when start=1 and abort=0; otherwise remain in IDLE.
- REQ-020 CLEAR SHALL last 1 cycle with nc_clear=1 and the address counter reset to 0.
- REQ-021 RUN SHALL last exactly NUM_WORDS cycles with mem_rd_en=1, nc_enable=1, and mem_addr stepping 0,1,...,NUM_WORDS-1, one increment per cycle.
- REQ-022 The address counter SHALL NOT wrap; RUN SHALL exit after mem_addr=NUM_WORDS-1.
- REQ-023 DRAIN SHALL last exactly 2 cycles with all nc_* strobes low, so that the final accumulate and the bias sum settle.
- REQ-024 RESULT SHALL last 1 cycle with nc_get_result=1.
- REQ-025 In CAPTURE (1 cycle), result SHALL load nc_out and done SHALL be 1; the next state is IDLE.
- REQ-026 Latency SHALL be fixed: when start is sampled at edge k, done is high in cycle k+NUM_WORDS+5.
- REQ-027 Outside RUN, mem_addr SHALL be 0 and mem_rd_en SHALL be 0.
- REQ-028 In any non-IDLE state, abort=1 SHALL force IDLE at the next edge; done SHALL stay low and result SHALL hold its previous value.
- REQ-029 abort=1 in IDLE SHALL override start.
- REQ-030 start SHALL be ignored while busy=1, including in CAPTURE.
- REQ-031 Every output SHALL be driven from a register; there SHALL be no combinational input-to-output path.

Reset
- REQ-032 While reset=0: state=IDLE, mem_addr=0, all strobes=0, busy=0, done=0, result=0, cycle_count=0.
- REQ-033 Reset asserted mid-RUN SHALL take effect immediately, with no completion pulse.
- REQ-034 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
- REQ-035 Macro NEURON_SEQ_CYCLE_CNT_EN: when defined, a 16-bit counter clears on entry to CLEAR, increments every non-IDLE cycle, saturates at 16'hFFFF, and holds its value in IDLE; cycle_count shows the counter.
- REQ-036 When NEURON_SEQ_CYCLE_CNT_EN is undefined, cycle_count SHALL be constant 0 and no counter logic SHALL be synthesised.

Verification
- REQ-037 NUM_WORDS=4: pulse start -> mem_addr 0,1,2,3 with mem_rd_en=nc_enable=1 for 4 cycles, nc_get_result pulses once, done at cycle k+9.
- REQ-038 Model nc_out=1 at CAPTURE -> result=1 and done=1 for exactly 1 cycle; busy falls the following cycle.
- REQ-039 Abort in the 2nd RUN cycle -> IDLE next edge, mem_rd_en=0, no done, result unchanged from the prior run.
- REQ-040 start held high continuously -> back-to-back runs with one IDLE cycle between done and the next CLEAR; start in CAPTURE not double-counted.
- REQ-041 reset=0 mid-DRAIN -> all outputs 0 asynchronously; start after release completes normally.
- REQ-042 With NEURON_SEQ_CYCLE_CNT_EN and NUM_WORDS=4 -> cycle_count=9 after done; without the macro -> cycle_count=0 throughout.
